wash_timer: RTL and testbench

Parametrised successor to the phase timer in the washing-machine controller. It counts `timer_period` seconds, where one second is `clk_freq` clock cycles. Over the fixed single-shot timer it adds explicit start and abort control, hold via `enable`, an auto-reload (periodic) mode, and per-second tick and remaining-seconds outputs. It sits between the cycle-sequencing FSM (fill/wash/rinse/spin) and the phase-duration constants, and drives phase advance and the front-panel countdown.

---
 rtl/wash_timer_if.sv | 26 ++
 rtl/wash_timer.sv | 114 +++++++++++
 tb/tb_wash_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_timer_if.sv
// Control/status bundle between the cycle sequencer and the wash timer.
interface wash_timer_if #(
  parameter int FREQ_W   = 16,
  parameter int PERIOD_W = 16
);
  logic                start;
  logic                abort;
  logic                enable;
  logic                periodic;
  logic [FREQ_W-1:0]   clk_freq;
  logic [PERIOD_W-1:0] timer_period;
  logic                busy;
  logic                tick;
  logic                done;
  logic [PERIOD_W-1:0] remaining;

  modport master (
    output start, abort, enable, periodic, clk_freq, timer_period,
    input  busy, tick, done, remaining
  );

  modport slave (
    input  start, abort, enable, periodic, clk_freq, timer_period,
    output busy, tick, done, remaining
  );
endinterface

// File: rtl/wash_timer.sv
// Phase timer: counts timer_period seconds of clk_freq cycles each, with
// hold (enable), abort, one-shot/periodic modes, per-second tick and a
// registered remaining-seconds countdown.
module wash_timer #(
  parameter int FREQ_W   = 16,
  parameter int PERIOD_W = 16
) (
  input logic         clk,
  input logic         reset,
  wash_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [FREQ_W-1:0]   presc, presc_d;
  logic [FREQ_W-1:0]   freq_last;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] remaining, rem_d;
  logic                mode_q, mode_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  // freq_q is never 0 while busy, so this cannot underflow when used.
  assign freq_last = freq_q - 1'b1;

  // State and datapath registers; every output comes straight from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      freq_q    <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      presc     <= '0;
      remaining <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      presc     <= presc_d;
      remaining <= rem_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update; abort beats start beats enable.
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    period_d = period_q;
    mode_d   = mode_q;
    presc_d  = presc;
    rem_d    = remaining;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.clk_freq == '0 || bus.timer_period == '0) begin
            // Degenerate request: complete immediately without running.
            done_d = 1'b1;
          end else begin
            freq_d   = bus.clk_freq;
            period_d = bus.timer_period;
            mode_d   = bus.periodic;
            presc_d  = '0;
            rem_d    = bus.timer_period;
            state_d  = bus.enable ? RUN : HOLD;
          end
        end
      end
      RUN, HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
          presc_d = '0;
          rem_d   = '0;
        end else if (bus.enable) begin
          // Leaving HOLD counts this cycle too, so a pause of N cycles
          // shifts completion by exactly N.
          state_d = RUN;
          if (presc == freq_last) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (remaining == PERIOD_W'(1)) begin
              done_d = 1'b1;
              if (mode_q) begin
                rem_d = period_q;
              end else begin
                rem_d   = '0;
                state_d = IDLE;
              end
            end else begin
              rem_d = remaining - 1'b1;
            end
          end else begin
            presc_d = presc + 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining;
endmodule

// File: tb/tb_wash_timer.sv
// Bench for wash_timer: directed scenarios plus random traffic, all checked
// against an elapsed-cycle arithmetic model of the timer.
module tb_wash_timer;
  localparam int FW = 16;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wash_timer_if #(.FREQ_W(FW), .PERIOD_W(PW)) bus ();
  wash_timer #(.FREQ_W(FW), .PERIOD_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: count enabled cycles since start; everything else
  // follows by division.
  bit     m_active;
  longint m_elapsed, m_freq, m_period;
  bit     m_mode;
  bit     e_busy, e_tick, e_done;
  logic [PW-1:0] e_rem;

  // Observation bookkeeping relative to the start edge (edge 0).
  int edge_no, first_done, done_cnt, tick_cnt;

  task automatic model_update();
    longint secs;
    e_tick = 0;
    e_done = 0;
    if (reset) m_active = 0;
    else if (m_active && bus.abort) m_active = 0;
    else if (!m_active && bus.start && !bus.abort) begin
      if (bus.clk_freq == 0 || bus.timer_period == 0) e_done = 1;
      else begin
        m_active = 1; m_elapsed = 0;
        m_freq = bus.clk_freq; m_period = bus.timer_period; m_mode = bus.periodic;
      end
    end else if (m_active && bus.enable) begin
      m_elapsed++;
      if (m_elapsed % m_freq == 0) begin
        e_tick = 1;
        secs = m_elapsed / m_freq;
        if (secs % m_period == 0) begin
          e_done = 1;
          if (!m_mode) m_active = 0;
        end
      end
    end
    e_busy = m_active;
    e_rem = m_active ? PW'(m_period - (m_elapsed / m_freq) % m_period) : '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    edge_no++;
    #1;
    if (bus.done && first_done < 0) first_done = edge_no;
    done_cnt += int'(bus.done);
    tick_cnt += int'(bus.tick);
  endtask

  function automatic logic [PW+2:0] got_vec();
    return {bus.busy, bus.tick, bus.done, bus.remaining};
  endfunction

  function automatic logic [PW+2:0] exp_vec();
    return {e_busy, e_tick, e_done, e_rem};
  endfunction

  task automatic quiet();
    bus.start = 0; bus.abort = 0; bus.enable = 1; reset = 0;
  endtask

  // Return to idle and issue a start on the next edge (edge 0).
  task automatic launch(input int f, input int p, input bit per);
    quiet(); bus.abort = 1; cycle(); cycle();
    quiet();
    bus.start = 1; bus.clk_freq = FW'(f); bus.timer_period = PW'(p); bus.periodic = per;
    edge_no = -1; first_done = -1; done_cnt = 0; tick_cnt = 0;
    cycle();
    bus.start = 0;
  endtask

  task automatic test_reset();
    reset = 1; bus.start = 0; bus.abort = 0; bus.enable = 0;
    bus.periodic = 0; bus.clk_freq = '0; bus.timer_period = '0;
    cycle(); cycle();
    vectors++;
    if (got_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset: got %h want 0", got_vec());
    end
    reset = 0;
  endtask

  task automatic test_oneshot();
    launch(5, 1, 0);
    for (int e = 1; e <= 9; e++) begin
      cycle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL oneshot e%0d: got %h want %h", e, got_vec(), exp_vec());
      end
    end
    vectors++;
    if (first_done !== 5 || done_cnt !== 1 || tick_cnt !== 1) begin
      miscompares++;
      $display("FAIL oneshot_timing: done@%0d x%0d ticks %0d want 5 x1 1", first_done, done_cnt, tick_cnt);
    end
  endtask

  task automatic test_countdown();
    launch(4, 3, 0);
    for (int e = 1; e <= 15; e++) begin
      cycle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL countdown e%0d: got %h want %h", e, got_vec(), exp_vec());
      end
      if (e == 8) begin
        vectors++;
        if (bus.remaining !== PW'(1) || bus.tick !== 1'b1) begin
          miscompares++;
          $display("FAIL countdown_e8: rem %0d tick %0b want 1 1", bus.remaining, bus.tick);
        end
      end
    end
    vectors++;
    if (first_done !== 12 || done_cnt !== 1 || tick_cnt !== 3) begin
      miscompares++;
      $display("FAIL countdown_timing: done@%0d x%0d ticks %0d want 12 x1 3", first_done, done_cnt, tick_cnt);
    end
  endtask

  task automatic test_hold();
    launch(4, 3, 0);
    for (int e = 1; e <= 22; e++) begin
      bus.enable = !(e >= 5 && e < 12);
      cycle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold e%0d: got %h want %h", e, got_vec(), exp_vec());
      end
    end
    bus.enable = 1;
    vectors++;
    if (first_done !== 19 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL hold_timing: done@%0d x%0d want 19 x1", first_done, done_cnt);
    end
  endtask

  task automatic test_periodic();
    launch(3, 2, 1);
    for (int e = 1; e <= 20; e++) begin
      bus.abort = (e == 14);
      cycle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL periodic e%0d: got %h want %h", e, got_vec(), exp_vec());
      end
      if (e == 6) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.remaining !== PW'(2) || bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL periodic_reload: done %0b rem %0d busy %0b want 1 2 1", bus.done, bus.remaining, bus.busy);
        end
      end
      if (e == 14) begin
        vectors++;
        if (bus.busy !== 1'b0 || bus.remaining !== '0) begin
          miscompares++;
          $display("FAIL periodic_abort: busy %0b rem %0d want 0 0", bus.busy, bus.remaining);
        end
      end
    end
    bus.abort = 0;
    vectors++;
    if (first_done !== 6 || done_cnt !== 2) begin
      miscompares++;
      $display("FAIL periodic_count: done@%0d x%0d want 6 x2", first_done, done_cnt);
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 2; k++) begin
      launch(k == 0 ? 5 : 0, k == 0 ? 0 : 3, 0);
      vectors++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tick !== 1'b0) begin
        miscompares++;
        $display("FAIL zero%0d: done %0b busy %0b tick %0b want 1 0 0", k, bus.done, bus.busy, bus.tick);
      end
      for (int e = 1; e <= 4; e++) cycle();
      vectors++;
      if (done_cnt !== 1 || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL zero%0d_after: done x%0d got %h want x1 %h", k, done_cnt, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_start_busy();
    launch(4, 3, 0);
    for (int e = 1; e <= 14; e++) begin
      bus.start = (e == 5);
      bus.clk_freq = FW'(1); bus.timer_period = PW'(1);
      cycle();
    end
    bus.start = 0;
    vectors++;
    if (first_done !== 12 || done_cnt !== 1 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL start_busy: done@%0d x%0d want 12 x1", first_done, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    launch(5, 1, 0);
    for (int e = 1; e <= 12; e++) begin
      reset = (e == 3);
      cycle();
      if (e == 3) begin
        vectors++;
        if (got_vec() !== '0) begin
          miscompares++;
          $display("FAIL reset_mid: got %h want 0", got_vec());
        end
      end
    end
    reset = 0;
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_done: done x%0d want x0", done_cnt);
    end
  endtask

  task automatic test_start_abort();
    quiet(); bus.abort = 1; cycle(); cycle();
    bus.start = 1; bus.abort = 1; bus.clk_freq = FW'(2); bus.timer_period = PW'(1);
    done_cnt = 0;
    cycle();
    quiet();
    for (int e = 1; e <= 6; e++) cycle();
    vectors++;
    if (done_cnt !== 0 || bus.busy !== 1'b0 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL start_abort: done x%0d busy %0b want x0 0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_random();
    quiet();
    for (int i = 0; i < 3000; i++) begin
      bus.start        = ($urandom_range(0, 9) == 0);
      bus.abort        = ($urandom_range(0, 39) == 0);
      reset            = ($urandom_range(0, 199) == 0);
      bus.enable       = ($urandom_range(0, 4) != 0);
      bus.periodic     = 1'($urandom);
      bus.clk_freq     = FW'($urandom_range(0, 4));
      bus.timer_period = PW'($urandom_range(0, 4));
      cycle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random i%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    quiet();
  endtask

  initial begin
    m_active = 0; m_elapsed = 0; m_freq = 1; m_period = 1; m_mode = 0;
    edge_no = 0; first_done = -1; done_cnt = 0; tick_cnt = 0;
    test_reset();
    test_oneshot();
    test_countdown();
    test_hold();
    test_periodic();
    test_zero();
    test_start_busy();
    test_reset_mid();
    test_start_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
